sample_reader: RTL and testbench
================================

SAMPLE_READER -- requirements
Module: sample_reader

Interface
REQ-001 Parameter DEPTH, default 640, number of stored samples (one per VGA column).
REQ-002 Parameter TRIG_LEVEL, default 8'd128, trigger threshold, used only with TRIG_EN.
REQ-003 clk  in  1  read-side clock; sole clock of the block.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 data_in  in  8  FIFO read data; valid the cycle after a pop.
REQ-006 fifo_empty  in  1  FIFO read-side empty flag.
REQ-007 read_busy  out  1  when 0 and fifo_empty=0, the capture side pops one byte that cycle.
REQ-008 capture_en  in  1  level; 1 permits capture and re-arm.
REQ-009 frame_done  in  1  one-cycle pulse at the end of the displayed frame.
REQ-010 rd_addr  in  10  display column address.
REQ-011 rd_data  out  8  stored sample at rd_addr.
REQ-012 buf_valid  out  1  1 while the buffer holds a complete capture.

Function
REQ-013 pop = ~read_busy & ~fifo_empty; pop_pending <= pop; data_in SHALL be consumed only on cycles with pop_pending=1.
REQ-014 States: IDLE, ARM, FILL, HOLD; wr_ptr is ceil(log2(DEPTH+1)) bits.
REQ-015 IDLE: read_busy=1; capture_en=1 -> wr_ptr<=0 and go to FILL (ARM when TRIG_EN is defined).
REQ-016 FILL: read_busy = (wr_ptr + pop_pending >= DEPTH); on pop_pending, mem[wr_ptr]<=data_in and wr_ptr++.
REQ-017 FILL -> HOLD when wr_ptr==DEPTH and pop_pending=0; no more than DEPTH bytes are ever popped per capture.
REQ-018 HOLD: read_busy=1, buf_valid=1; frame_done -> wr_ptr<=0, then go to FILL/ARM if capture_en=1, else IDLE.
REQ-019 buf_valid=0 in every state other than HOLD.
REQ-020 Dropping capture_en in ARM or FILL does not abort; the current capture completes to HOLD.
REQ-021 frame_done outside HOLD is ignored.
REQ-022 fifo_empty=1 stalls FILL indefinitely with no timeout; wr_ptr holds its value.
REQ-023 rd_data is registered with 1-cycle latency: rd_data <= (rd_addr < DEPTH) ? mem[rd_addr] : 8'd0; reads are allowed in every state.
REQ-024 A write and a read at the same address in the same cycle return the old contents.

Reset
REQ-025 reset=0 asynchronously sets state=IDLE, wr_ptr=0, pop_pending=0, buf_valid=0, rd_data=0 and read_busy=1.
REQ-026 Memory contents are not reset; a byte in flight during reset is discarded.
REQ-027 After release, the first pop occurs no earlier than the second rising clk edge.

Configuration
REQ-028 Macro SAMPLE_READER_TRIG_EN defined: ARM is entered instead of FILL, with read_busy=0 and prev<=8'hFF on entry.
REQ-029 In ARM, each pop_pending byte updates prev.
REQ-030 In ARM, prev<TRIG_LEVEL and data_in>=TRIG_LEVEL stores the byte at address 0, sets wr_ptr=1 and goes to FILL; non-triggering bytes are discarded.
REQ-031 A byte popped on the trigger cycle is stored at address 1.
REQ-032 Macro undefined: ARM is unreachable and capture starts with the first popped byte.

Verification
REQ-033 DEPTH=8, capture_en=1, FIFO never empty, bytes 1..20 -> exactly 8 pops; mem=1..8; HOLD with buf_valid=1.
REQ-034 fifo_empty toggles every 3 cycles -> no pop while empty; mem holds consecutive bytes with no loss or duplication.
REQ-035 In HOLD, rd_addr=3 -> rd_data=4 one cycle later; rd_addr=700 -> rd_data=0.
REQ-036 frame_done in HOLD with capture_en=0 -> IDLE, read_busy=1, buf_valid=0; with capture_en=1 -> refill with bytes 9..16.
REQ-037 reset asserted after 4 writes -> outputs at reset values immediately; the following capture restarts at address 0.
REQ-038 TRIG_EN defined, byte stream 200,50,100,130,140,... -> mem[0]=130, mem[1]=140; bytes 200, 50 and 100 are discarded.

Source files
------------

// File: rtl/sample_reader_if.sv
// sample_reader_if
//   Groups the FIFO read handshake and the display read port of sample_reader.
//   master : FIFO/display side (drives read data, empty flag, column address)
//   slave  : sample_reader side (drives read_busy and the stored sample)
//   data_in    [7:0] FIFO read data, valid the cycle after a pop
//   fifo_empty       FIFO read-side empty flag
//   read_busy        0 with fifo_empty=0 means one byte is popped this cycle
//   rd_addr    [9:0] display column address
//   rd_data    [7:0] stored sample at rd_addr, one cycle latency
interface sample_reader_if;
   logic [7:0] data_in;
   logic       fifo_empty;
   logic       read_busy;
   logic [9:0] rd_addr;
   logic [7:0] rd_data;

   modport master (
      output data_in,
      output fifo_empty,
      output rd_addr,
      input  read_busy,
      input  rd_data
   );

   modport slave (
      input  data_in,
      input  fifo_empty,
      input  rd_addr,
      output read_busy,
      output rd_data
   );
endinterface

// File: rtl/sample_reader.sv
// sample_reader
//   Pulls DEPTH bytes from a FIFO into a sample buffer, holds them for the
//   display until the end of a frame, then re-arms or idles.
//   Optional macro SAMPLE_READER_TRIG_EN: each capture starts with a rising
//   crossing of TRIG_LEVEL instead of the first popped byte.
// Ports
//   clk        read-side clock, sole clock of the block
//   reset      asynchronous active-low reset
//   bus        sample_reader_if.slave (FIFO handshake + display read port)
//   capture_en level, permits capture and re-arm
//   frame_done one-cycle pulse at the end of the displayed frame
//   buf_valid  high while the buffer holds a complete capture
module sample_reader #(
   parameter int         DEPTH      = 640,
   parameter logic [7:0] TRIG_LEVEL = 8'd128
) (
   input  logic                   clk,
   input  logic                   reset,
   sample_reader_if.slave         bus,
   input  logic                   capture_en,
   input  logic                   frame_done,
   output logic                   buf_valid
);

   localparam int PW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [10:0]   DEPTH_A = 11'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      FILL = 2'd2,
      HOLD = 2'd3
   } state_t;

`ifdef SAMPLE_READER_TRIG_EN
   localparam state_t START_ST = ARM;
`else
   localparam state_t START_ST = FILL;
`endif

   state_t         state_r, state_s;
   logic [PW-1:0]  wr_ptr_r, wr_ptr_s;
   logic [PW:0]    wr_sum_s;
   logic           pop_pending_r;
   logic           pop_s;
   logic           read_busy_s;
   logic [7:0]     prev_r, prev_s;
   logic           buf_valid_r;
   logic [7:0]     rd_data_r;
   logic           wr_en_s;
   logic [AW-1:0]  wr_addr_s;
   logic [7:0]     wr_data_s;
   logic [7:0]     mem_r [DEPTH];

   // Counting the byte still in flight keeps the total pops at exactly DEPTH.
   assign wr_sum_s      = {1'b0, wr_ptr_r} + (PW+1)'(pop_pending_r);
   assign pop_s         = ~read_busy_s & ~bus.fifo_empty;
   assign bus.read_busy = read_busy_s;
   assign bus.rd_data   = rd_data_r;
   assign buf_valid     = buf_valid_r;

   // Next-state, pointer, trigger history and buffer write decode.
   always_comb begin
      state_s     = state_r;
      wr_ptr_s    = wr_ptr_r;
      prev_s      = prev_r;
      read_busy_s = 1'b1;
      wr_en_s     = 1'b0;
      wr_addr_s   = '0;
      wr_data_s   = bus.data_in;
      case (state_r)
         IDLE: begin
            if (capture_en) begin
               wr_ptr_s = '0;
               prev_s   = 8'hFF;
               state_s  = START_ST;
            end else begin
               state_s  = IDLE;
            end
         end
         ARM: begin
            // Keep popping and discarding until a rising crossing shows up.
            read_busy_s = 1'b0;
            if (pop_pending_r) begin
               prev_s = bus.data_in;
               if ((prev_r < TRIG_LEVEL) && (bus.data_in >= TRIG_LEVEL)) begin
                  wr_en_s   = 1'b1;
                  wr_addr_s = '0;
                  wr_ptr_s  = PW'(1);
                  state_s   = FILL;
               end else begin
                  state_s   = ARM;
               end
            end else begin
               state_s = ARM;
            end
         end
         FILL: begin
            read_busy_s = (wr_sum_s >= {1'b0, DEPTH_P});
            if (pop_pending_r) begin
               wr_en_s   = 1'b1;
               wr_addr_s = wr_ptr_r[AW-1:0];
               wr_ptr_s  = wr_ptr_r + PW'(1);
            end else if (wr_ptr_r == DEPTH_P) begin
               state_s   = HOLD;
            end else begin
               state_s   = FILL;
            end
         end
         HOLD: begin
            if (frame_done) begin
               wr_ptr_s = '0;
               if (capture_en) begin
                  prev_s  = 8'hFF;
                  state_s = START_ST;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Control registers; an in-flight byte is dropped by clearing pop_pending.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         wr_ptr_r      <= '0;
         pop_pending_r <= 1'b0;
         prev_r        <= 8'hFF;
         buf_valid_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         wr_ptr_r      <= wr_ptr_s;
         pop_pending_r <= pop_s;
         prev_r        <= prev_s;
         buf_valid_r   <= (state_s == HOLD);
      end
   end

   // Sample buffer write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_addr_s] <= wr_data_s;
      end
   end

   // Registered display read; same-address write returns the old byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_r <= 8'd0;
      end else if ({1'b0, bus.rd_addr} < DEPTH_A) begin
         rd_data_r <= mem_r[bus.rd_addr[AW-1:0]];
      end else begin
         rd_data_r <= 8'd0;
      end
   end

endmodule

// File: tb/tb_sample_reader.sv
module tb_sample_reader;
   localparam int         DEPTH = 8;
   localparam logic [7:0] TL    = 8'd128;

   logic clk        = 1'b0;
   logic reset      = 1'b0;
   logic capture_en = 1'b0;
   logic frame_done = 1'b0;
   logic buf_valid;

   sample_reader_if bus ();

   sample_reader #(.DEPTH(DEPTH), .TRIG_LEVEL(TL)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .capture_en (capture_en),
      .frame_done (frame_done),
      .buf_valid  (buf_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] addr;
      logic [7:0] exp;
   } rd_vec_t;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] src [0:1023];
   int         src_idx  = 0;
   logic [7:0] cap_q [$];
   rd_vec_t    tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // One clock: decide the pop from pre-edge values, then deliver FIFO data.
   task automatic tick();
      logic pop;
      pop = (bus.read_busy === 1'b0) && !bus.fifo_empty;
      @(posedge clk);
      #1;
      if (pop) begin
         bus.data_in = src[src_idx];
         cap_q.push_back(src[src_idx]);
         src_idx = (src_idx + 1) % 1024;
      end
   endtask

   task automatic pulse_frame_done();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
   endtask

   // mode 0: never empty, 1: empty toggles every 3 cycles, 2: random empty
   task automatic run_capture(input int mode, input int drop_at);
      logic done;
      done = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (buf_valid === 1'b1) begin
            done = 1'b1;
            break;
         end
         case (mode)
            0:       bus.fifo_empty = 1'b0;
            1:       bus.fifo_empty = ((c / 3) % 2) == 1;
            default: bus.fifo_empty = 1'($urandom_range(0, 1));
         endcase
         if (drop_at > 0 && cap_q.size() == drop_at) capture_en = 1'b0;
         tick();
      end
      if (buf_valid === 1'b1) done = 1'b1;
      check("hold_reached", {31'd0, done}, 32'd1);
      bus.fifo_empty = 1'b0;
   endtask

   // Buffer must hold exactly the DEPTH bytes starting at cap_q[base].
   task automatic verify_mem(input string tag, input int base);
      logic [7:0] exp_b [DEPTH];
      check({tag, "_pops"}, cap_q.size(), base + DEPTH);
      for (int i = 0; i < DEPTH; i++)
         exp_b[i] = (base + i < cap_q.size()) ? cap_q[base + i] : 8'h00;
      bus.fifo_empty = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         bus.rd_addr = 10'(i);
         tick();
         check({tag, "_mem"}, bus.rd_data, exp_b[i]);
      end
      check({tag, "_no_pop_in_hold"}, cap_q.size(), base + DEPTH);
      check({tag, "_buf_valid"}, buf_valid, 1);
      check({tag, "_busy_in_hold"}, bus.read_busy, 1);
   endtask

   initial begin
      bus.data_in    = 8'd0;
      bus.fifo_empty = 1'b0;
      bus.rd_addr    = 10'd0;

`ifdef SAMPLE_READER_TRIG_EN
      src[0] = 8'd200; src[1] = 8'd50; src[2] = 8'd100; src[3] = 8'd130; src[4] = 8'd140;
      for (int k = 5; k < 1024; k++) src[k] = 8'((k * 10 + 110) % 256);
`else
      for (int k = 0; k < 1024; k++) src[k] = 8'((k + 1) % 256);
`endif

      #12;
      check("reset_read_busy", bus.read_busy, 1);
      check("reset_buf_valid", buf_valid, 0);
      check("reset_rd_data", bus.rd_data, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

`ifdef SAMPLE_READER_TRIG_EN
      begin
         int   start;
         logic [7:0] prev;
         capture_en = 1'b1;
         cap_q.delete();
         run_capture(0, 0);
         start = -1;
         prev  = 8'hFF;
         for (int i = 0; i < cap_q.size(); i++) begin
            if (prev < TL && cap_q[i] >= TL) begin
               start = i;
               break;
            end
            prev = cap_q[i];
         end
         check("trig_start", start, 3);
         verify_mem("trig", (start < 0) ? 0 : start);
         bus.rd_addr = 10'd0; tick(); check("trig_mem0", bus.rd_data, 130);
         bus.rd_addr = 10'd1; tick(); check("trig_mem1", bus.rd_data, 140);
      end
`else
      // First capture: bytes 1..8, nothing popped on the first edge.
      capture_en = 1'b1;
      cap_q.delete();
      tick();
      check("no_pop_first_edge", cap_q.size(), 0);
      run_capture(0, 0);
      verify_mem("cap1", 0);

      tbl[0] = '{10'd3,    8'd4};
      tbl[1] = '{10'd0,    8'd1};
      tbl[2] = '{10'd7,    8'd8};
      tbl[3] = '{10'd1,    8'd2};
      tbl[4] = '{10'd5,    8'd6};
      tbl[5] = '{10'd8,    8'd0};
      tbl[6] = '{10'd700,  8'd0};
      tbl[7] = '{10'd1023, 8'd0};
      tbl[8] = '{10'd6,    8'd7};
      tbl[9] = '{10'd2,    8'd3};
      for (int v = 0; v < 10; v++) begin
         bus.rd_addr = tbl[v].addr;
         tick();
         check($sformatf("tbl_rd_%0d", tbl[v].addr), bus.rd_data, tbl[v].exp);
      end

      // End of frame with capture disabled goes idle; stray frame_done ignored.
      capture_en = 1'b0;
      pulse_frame_done();
      check("idle_buf_valid", buf_valid, 0);
      check("idle_read_busy", bus.read_busy, 1);
      pulse_frame_done();
      tick();
      check("idle_stray_fd_busy", bus.read_busy, 1);
      check("idle_stray_fd_valid", buf_valid, 0);

      // Re-capture from idle: bytes 9..16.
      capture_en = 1'b1;
      cap_q.delete();
      run_capture(0, 0);
      verify_mem("cap2", 0);
      bus.rd_addr = 10'd7; tick(); check("cap2_last", bus.rd_data, 16);

      // Refill straight from HOLD with a gappy FIFO.
      cap_q.delete();
      pulse_frame_done();
      run_capture(1, 0);
      verify_mem("toggle", 0);

      // Dropping capture_en mid-fill still completes, then idles at frame end.
      cap_q.delete();
      pulse_frame_done();
      run_capture(2, 3);
      verify_mem("drop", 0);
      pulse_frame_done();
      check("drop_idle_valid", buf_valid, 0);
      check("drop_idle_busy", bus.read_busy, 1);

      // Randomised captures.
      capture_en = 1'b1;
      for (int r = 0; r < 4; r++) begin
         cap_q.delete();
         if (buf_valid) pulse_frame_done();
         run_capture(2, 0);
         verify_mem($sformatf("rand%0d", r), 0);
      end

      // Reset part-way through a capture.
      bus.rd_addr = 10'd0;
      tick();
      cap_q.delete();
      pulse_frame_done();
      for (int c = 0; c < 50 && cap_q.size() < 4; c++) tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("midreset_read_busy", bus.read_busy, 1);
      check("midreset_buf_valid", buf_valid, 0);
      check("midreset_rd_data", bus.rd_data, 0);
      tick();
      reset = 1'b1;
      cap_q.delete();
      bus.fifo_empty = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      check("stall_no_pop", cap_q.size(), 0);
      check("stall_buf_valid", buf_valid, 0);
      check("stall_read_busy", bus.read_busy, 0);
      run_capture(0, 0);
      verify_mem("after_reset", 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
